// File: rtl/pb_page_alloc_if.sv
// pb_page_alloc_if: allocation, free and status channels of the packet buffer page allocator.
interface pb_page_alloc_if #(
  parameter int asz = 6,
  parameter int ports = 4,
  parameter int pw = 2
);
  logic [ports-1:0] alc_srdy;
  logic [ports-1:0] alc_drdy;
  logic [asz-1:0]   alc_page;
  logic             fre_srdy;
  logic             fre_drdy;
  logic [asz-1:0]   fre_page;
  logic [pw-1:0]    fre_port;
  logic [asz:0]     free_count;
  logic             init_done;
  logic             err;
  modport master (
    output alc_srdy, fre_srdy, fre_page, fre_port,
    input  alc_drdy, alc_page, fre_drdy, free_count, init_done, err
  );
  modport slave (
    input  alc_srdy, fre_srdy, fre_page, fre_port,
    output alc_drdy, alc_page, fre_drdy, free_count, init_done, err
  );
endinterface

// File: rtl/pb_page_alloc.sv
// pb_page_alloc: round-robin page allocator over a circular free-list FIFO.
// Optional per-port page quota is built when PB_ALLOC_QUOTA_EN is defined.
module pb_page_alloc #(
  parameter int pages = 64,
  parameter int asz = 6,
  parameter int ports = 4,
  parameter int pw = 2,
  parameter int quota = 24
) (
  input  logic          clk,
  input  logic          reset,
  pb_page_alloc_if.slave b
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [asz:0] FULL = (asz+1)'(pages);
  state_t state_q, state_d;
  logic run, wen, push, pop, ovf, unf, found;
  logic [asz-1:0] mem [pages];
  logic [asz-1:0] wr_q, wr_d, rd_q, rd_d, wdata;
  logic [asz:0] cnt_q, cnt_d;
  logic [pw-1:0] rr_q, rr_d, gidx, idx;
  logic [ports-1:0] elig, qok, gnt;
  logic err_q, err_d;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= INIT;
    else state_q <= state_d;

  always_comb state_d = (state_q == INIT && wr_q == asz'(pages-1)) ? RUN : state_q;

  always_comb begin
    run = state_q == RUN;
    b.init_done = run;
    b.fre_drdy = run;
    b.alc_drdy = gnt;
    b.alc_page = (run && cnt_q != '0) ? mem[rd_q] : '0;
    b.free_count = cnt_q;
    b.err = err_q;
  end

  assign elig = b.alc_srdy & qok & {ports{run && cnt_q != '0}};

  // scan from rr upward; pw-bit addition wraps modulo ports
  always_comb begin
    found = 1'b0;
    gidx = rr_q;
    idx = rr_q;
    for (int k = 0; k < ports; k++) begin
      idx = rr_q + pw'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx = idx;
      end
    end
    gnt = found ? (ports'(1) << gidx) : '0;
  end

  // INIT reuses the write pointer as the page id being seeded
  always_comb begin
    pop = |gnt;
    push = b.fre_srdy && run && cnt_q != FULL;
    ovf = b.fre_srdy && run && cnt_q == FULL;
    wen = !run || push;
    wdata = run ? b.fre_page : wr_q;
    wr_d = wr_q + asz'(wen);
    rd_d = rd_q + asz'(pop);
    cnt_d = cnt_q + (asz+1)'(wen) - (asz+1)'(pop);
    rr_d = pop ? gidx + pw'(1) : rr_q;
    err_d = err_q | ovf | unf;
  end

  always_ff @(posedge clk)
    if (wen) mem[wr_q] <= wdata;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      err_q <= err_d;
    end

`ifdef PB_ALLOC_QUOTA_EN
  logic [asz:0] used_q [ports];
  logic [asz:0] used_d [ports];
  always_comb begin
    unf = b.fre_srdy && run && used_q[b.fre_port] == '0;
    for (int i = 0; i < ports; i++) begin
      qok[i] = used_q[i] < (asz+1)'(quota);
      used_d[i] = used_q[i] + (asz+1)'(pop && gidx == pw'(i))
                - (asz+1)'(b.fre_srdy && run && b.fre_port == pw'(i) && used_q[i] != '0);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) used_q <= '{default: '0};
    else used_q <= used_d;
`else
  logic unused_fre_port;
  assign unused_fre_port = ^b.fre_port;
  always_comb begin
    qok = '1;
    unf = 1'b0;
  end
`endif
endmodule

// File: doc/pb_page_alloc.md
# pb_page_alloc

Page allocator and arbiter for the bridge packet buffer memory. It owns the free list of buffer pages and shares it between the `NUM_PORTS` port macros. Each port requests a page through an srdy/drdy channel, and the allocator grants one request per cycle in round-robin order. Freed pages are returned through a single free channel fed by the buffer read-out path.

## Interface
Parameters:
- `pages`, 64: number of buffer pages.
- `asz`, 6: page id width; must equal log2(`pages`).
- `ports`, 4: number of requesting ports.
- `pw`, 2: port index width; must equal log2(`ports`).
- `quota`, 24: maximum pages held by one port (used only with `PB_ALLOC_QUOTA_EN`).

Ports (clock and reset first):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `alc_srdy`  in  `ports`  per-port allocation request.
- `alc_drdy`  out  `ports`  one-hot grant; transfer occurs when `alc_srdy[i] & alc_drdy[i]`.
- `alc_page`  out  `asz`  granted page id; valid while any `alc_drdy` bit is high.
- `fre_srdy`  in  1  free request.
- `fre_drdy`  out  1  free accept.
- `fre_page`  in  `asz`  page being freed.
- `fre_port`  in  `pw`  owner port of the freed page.
- `free_count`  out  `asz+1`  pages currently on the free list.
- `init_done`  out  1  free list initialised.
- `err`  out  1  sticky protocol error.

## Operation
- State `INIT`:
  - entered on reset.
  - writes page ids 0..`pages`-1 into the free-list FIFO, one per cycle.
  - `free_count` increments each cycle.
  - `alc_drdy` and `fre_drdy` are 0.
  - moves to `RUN` after the write of id `pages`-1.
- State `RUN`:
  - final state; only reset leaves it.
  - `init_done`=1.
  - `fre_drdy`=1.
- Free list:
  - register-array circular FIFO, depth `pages`.
  - read and write pointers of `asz` bits wrap naturally.
  - `free_count` ranges 0..`pages`.
  - `alc_page` is the FIFO head.
- Arbitration:
  - eligible ports are those with `alc_srdy[i]` set (and, with `PB_ALLOC_QUOTA_EN`, `used[i]` < `quota`).
  - a grant needs `free_count`>0.
  - the highest-priority eligible port is chosen, starting at priority pointer `rr`.
  - after a grant, `rr` becomes the granted index+1, mod `ports`.
  - with no grant, `rr` holds.
- On allocation: pop the FIFO; with the macro, `used[i]`+1.
- On free:
  - push `fre_page`.
  - with the macro, `used[fre_port]`-1.
- Simultaneous alloc and free:
  - both complete in the same cycle and `free_count` is unchanged.
  - there is no bypass: with `free_count`=0, the freed page is not grantable until the next cycle.
- Error cases:
  - free while `free_count`=`pages`: sets `err`; the push is dropped.
  - with the macro, free while `used[fre_port]`=0: sets `err`; the push still occurs and `used` stays 0.
  - `err` clears only on reset.

## Timing
- Reset values:
  - `alc_drdy`=0, `fre_drdy`=0, `alc_page`=0, `free_count`=0, `init_done`=0, `err`=0.
  - `rr`=0, `used[*]`=0, state `INIT`.
- Initialisation: `init_done` rises exactly `pages` cycles after reset deasserts, at which point `free_count`=`pages`.
- Grant path:
  - `alc_drdy` is combinational from `alc_srdy`, registered state, `rr`, `free_count` and `used`.
  - a grant occurs in the same cycle as the request.
- Registered updates: pointers, `free_count`, `used`, `rr` and `err` update on the clock edge after the transfer.
- Free-to-reuse latency: a page freed in cycle N is allocatable in cycle N+1 at the earliest.
- Reset mid-operation: returns the block to `INIT` immediately; all allocations are forgotten and the free list is rebuilt.
- Grant rate: at most one grant per cycle.

## Configuration
- Macro `PB_ALLOC_QUOTA_EN`.
- Defined:
  - per-port `used` counters (`asz+1` bits) are built.
  - a port at `quota` is ineligible.
  - `fre_port` decrements its owner's counter.
  - the underflow error is active.
- Undefined:
  - no `used` counters are built and `quota` is ignored.
  - `fre_port` is unused.
  - only the overflow error sets `err`.

## Test plan
- Reset release:
  - `init_done`=0 for 64 cycles, then 1.
  - `free_count`=64.
  - no `alc_drdy` during `INIT`.
- Port 1 requests 3 consecutive cycles alone:
  - grants carry pages 0, 1, 2.
  - `free_count`=61.
- All four `alc_srdy` held high for 8 cycles: grants go to ports 0,1,2,3,0,1,2,3 with pages 0..7.
- Quota (macro on), port 0 held high alone:
  - 24 grants, then `alc_drdy`=0.
  - a free with `fre_port`=0 and page 3 lets port 0 be granted page 24 on the next cycle, not page 3.
- Exhaustion: allocate all 64 pages across ports (`free_count`=0), then free page 9 while all ports request:
  - no grant in the free cycle.
  - next cycle, `free_count`=1 and page 9 goes to the `rr` port.
- Errors:
  - a free with `fre_port`=2 while `used[2]`=0 sets `err`=1 (macro on).
  - a free at `free_count`=64 sets `err`=1.
  - asserting reset mid-run clears `err` and restarts `INIT`.
